// File: rtl/doce_tx_pkg.sv
// Shared definitions for the DoCE transmit framing FSM.
// Header field offsets are common with the receive-side extractor.
package doce_tx_pkg;

  localparam logic [3:0] ST_IDLE    = 4'b0001;
  localparam logic [3:0] ST_HEADER  = 4'b0010;
  localparam logic [3:0] ST_PAYLOAD = 4'b0100;
  localparam logic [3:0] ST_DROP    = 4'b1000;

  typedef enum logic [3:0] {
    IDLE    = ST_IDLE,
    HEADER  = ST_HEADER,
    PAYLOAD = ST_PAYLOAD,
    DROP    = ST_DROP
  } tx_state_t;

  localparam int TUSER_DROP_BIT = 2;

  localparam int HDR_SRC_LSB   = 0;
  localparam int HDR_DST_LSB   = 48;
  localparam int HDR_ETYPE_LSB = 96;
  localparam int HDR_SEQ_LSB   = 112;

  localparam int MAC_W  = 48;
  localparam int DATA_W = 128;
  localparam int KEEP_W = 16;
  localparam int USER_W = 4;

  function automatic logic [DATA_W-1:0] build_header(
    input logic [15:0]      seq,
    input logic [15:0]      etype,
    input logic [MAC_W-1:0] dst,
    input logic [MAC_W-1:0] src
  );
    logic [DATA_W-1:0] hdr;
    hdr = '0;
    hdr[HDR_SRC_LSB   +: MAC_W] = src;
    hdr[HDR_DST_LSB   +: MAC_W] = dst;
    hdr[HDR_ETYPE_LSB +: 16]    = etype;
    hdr[HDR_SEQ_LSB   +: 16]    = seq;
    return hdr;
  endfunction

endpackage

// File: rtl/tx_fsm.sv
// Transmit framing FSM: prepends a 16-byte link header to each transport frame
// and forwards it to the router; frames flagged for drop are swallowed.
module tx_fsm
  import doce_tx_pkg::*;
#(
  parameter logic [15:0] ETHERTYPE = 16'h88B5,
  parameter int          SEQ_W     = 16
) (
  input  logic                user_clk,
  input  logic                reset,
  input  logic [DATA_W-1:0]   axi_str_tdata_from_trans,
  input  logic [KEEP_W-1:0]   axi_str_tkeep_from_trans,
  input  logic                axi_str_tvalid_from_trans,
  input  logic                axi_str_tlast_from_trans,
  input  logic [USER_W-1:0]   axi_str_tuser_from_trans,
  output logic                axi_str_tready_to_trans,
  output logic [DATA_W-1:0]   axi_str_tdata_to_router,
  output logic [KEEP_W-1:0]   axi_str_tkeep_to_router,
  output logic                axi_str_tvalid_to_router,
  output logic                axi_str_tlast_to_router,
  output logic [USER_W-1:0]   axi_str_tuser_to_router,
  input  logic                axi_str_tready_from_router,
  input  logic [MAC_W-1:0]    tx_dst_mac_addr,
  input  logic [MAC_W-1:0]    tx_src_mac_addr,
  output logic [31:0]         frames_sent,
  output logic [15:0]         frames_dropped
);

  tx_state_t           state_reg, state_next;
  logic [SEQ_W-1:0]    seq_reg;
  logic [31:0]         frames_sent_reg;
  logic [15:0]         frames_dropped_reg;
  logic [MAC_W-1:0]    dst_mac_reg;
  logic [USER_W-1:0]   tuser_reg;

  logic                latch_en;
  logic                sent_inc;
  logic                drop_inc;
  logic                drop_flag;
  logic [15:0]         seq_hdr;

  assign drop_flag = axi_str_tuser_from_trans[TUSER_DROP_BIT];

  // Header always carries a 16-bit sequence field regardless of counter width.
  generate
    if (SEQ_W >= 16) begin : g_seq_trunc
      assign seq_hdr = seq_reg[15:0];
    end else begin : g_seq_ext
      assign seq_hdr = {{(16-SEQ_W){1'b0}}, seq_reg};
    end
  endgenerate

  always_ff @(posedge user_clk) begin
    if (reset) begin
      state_reg          <= IDLE;
      seq_reg            <= '0;
      frames_sent_reg    <= '0;
      frames_dropped_reg <= '0;
      dst_mac_reg        <= '0;
      tuser_reg          <= '0;
    end else begin
      state_reg <= state_next;
      if (latch_en) begin
        dst_mac_reg <= tx_dst_mac_addr;
        tuser_reg   <= axi_str_tuser_from_trans;
      end
      if (sent_inc) begin
        seq_reg         <= seq_reg + 1'b1;
        frames_sent_reg <= frames_sent_reg + 32'd1;
      end
      if (drop_inc && (frames_dropped_reg != 16'hFFFF)) begin
        frames_dropped_reg <= frames_dropped_reg + 16'd1;
      end
    end
  end

  always_comb begin
    state_next               = state_reg;
    latch_en                 = 1'b0;
    sent_inc                 = 1'b0;
    drop_inc                 = 1'b0;
    axi_str_tready_to_trans  = 1'b0;
    axi_str_tdata_to_router  = '0;
    axi_str_tkeep_to_router  = '0;
    axi_str_tvalid_to_router = 1'b0;
    axi_str_tlast_to_router  = 1'b0;
    axi_str_tuser_to_router  = '0;

    unique case (state_reg)
      IDLE: begin
        // A non-drop first beat is only observed here; it is consumed in PAYLOAD.
        if (axi_str_tvalid_from_trans) begin
          if (drop_flag) begin
            axi_str_tready_to_trans = 1'b1;
            if (axi_str_tlast_from_trans) drop_inc = 1'b1;
            else                          state_next = DROP;
          end else begin
            latch_en   = 1'b1;
            state_next = HEADER;
          end
        end
      end
      HEADER: begin
        axi_str_tvalid_to_router = 1'b1;
        axi_str_tkeep_to_router  = '1;
        axi_str_tdata_to_router  = build_header(seq_hdr, ETHERTYPE, dst_mac_reg, tx_src_mac_addr);
        axi_str_tuser_to_router  = tuser_reg;
        if (axi_str_tready_from_router) state_next = PAYLOAD;
      end
      PAYLOAD: begin
        axi_str_tdata_to_router  = axi_str_tdata_from_trans;
        axi_str_tkeep_to_router  = axi_str_tkeep_from_trans;
        axi_str_tvalid_to_router = axi_str_tvalid_from_trans;
        axi_str_tlast_to_router  = axi_str_tlast_from_trans;
        axi_str_tuser_to_router  = tuser_reg;
        axi_str_tready_to_trans  = axi_str_tready_from_router;
        if (axi_str_tvalid_from_trans && axi_str_tready_from_router &&
            axi_str_tlast_from_trans) begin
          state_next = IDLE;
          sent_inc   = 1'b1;
        end
      end
      DROP: begin
        axi_str_tready_to_trans = 1'b1;
        if (axi_str_tvalid_from_trans && axi_str_tlast_from_trans) begin
          state_next = IDLE;
          drop_inc   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign frames_sent    = frames_sent_reg;
  assign frames_dropped = frames_dropped_reg;

endmodule

// File: doc/tx_fsm.md
# tx_fsm

Transmit-side framing FSM for the DoCE transport layer. Accepts frames from the transport engine on a 128-bit AXI-Stream, prepends one 16-byte link header beat (source MAC, destination MAC, ethertype, frame sequence number), and forwards the frame to the router. Frames flagged for drop by the transport engine are consumed and discarded. Its header layout matches what the receive FSM extracts: destination MAC at bits [95:48] of beat 0.

## Interface
- ETHERTYPE, 16'h88B5: value placed in header bits [111:96].
- SEQ_W, 16: width of the frame sequence counter; header carries it zero-extended or truncated to 16 bits.
- user_clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- axi_str_tdata_from_trans  in  128  payload data; byte 0 at [7:0].
- axi_str_tkeep_from_trans  in  16  byte enables.
- axi_str_tvalid_from_trans  in  1  valid.
- axi_str_tlast_from_trans  in  1  last beat of frame.
- axi_str_tuser_from_trans  in  4  frame attributes; bit 2 = drop; sampled on first beat only.
- axi_str_tready_to_trans  out  1  ready.
- axi_str_tdata_to_router  out  128  header or payload data.
- axi_str_tkeep_to_router  out  16  byte enables.
- axi_str_tvalid_to_router  out  1  valid.
- axi_str_tlast_to_router  out  1  last.
- axi_str_tuser_to_router  out  4  first-beat tuser, held for the whole frame.
- axi_str_tready_from_router  in  1  router ready.
- tx_dst_mac_addr  in  48  destination MAC; sampled when a frame is accepted in IDLE.
- tx_src_mac_addr  in  48  local MAC; quasi-static.
- frames_sent  out  32  count of completed non-dropped frames.
- frames_dropped  out  16  count of discarded frames; saturates at 16'hFFFF.

## Operation
- The state machine has four states: IDLE, HEADER, PAYLOAD, DROP.
- IDLE:
  - tready_to_trans=0 unless tvalid & tuser[2]. When that holds, tready_to_trans=1 and the beat is consumed.
  - If that beat also has tlast, stay in IDLE and increment frames_dropped. Otherwise go to DROP.
  - If tvalid & !tuser[2], latch tx_dst_mac_addr and tuser, then go to HEADER. The beat is not consumed.
- HEADER:
  - tvalid_to_router=1, tkeep=16'hFFFF, tlast=0, tuser=latched value.
  - tdata = {seq[15:0], ETHERTYPE, latched dst MAC, tx_src_mac_addr}, with tx_src_mac_addr in the low bits.
  - tready_to_trans=0. On tready_from_router, go to PAYLOAD.
- PAYLOAD:
  - Combinational pass-through. tdata, tkeep, tvalid and tlast to the router equal the trans inputs.
  - tready_to_trans = tready_from_router. tuser_to_router = latched tuser; mid-frame tuser changes are ignored.
  - On a tlast handshake, go to IDLE, increment seq and frames_sent (both wrap).
- DROP: tready_to_trans=1 and router outputs are deasserted. On a tvalid & tlast beat, go to IDLE and increment frames_dropped.
- Router outputs in IDLE and DROP: all zero.
- tx_dst_mac_addr changes after latching do not affect the frame in flight.

## Timing
- Reset values:
  - State IDLE, seq=0, frames_sent=0, frames_dropped=0, latched registers 0.
  - All router outputs 0 and tready_to_trans=0.
- Header latency: the header is presented the cycle after the first trans beat is seen in IDLE. Payload beat 0 can transfer the cycle after the header handshake.
- Throughput: 1 beat/cycle in PAYLOAD. There is one idle cycle (IDLE) between frames, plus the header beat, so frame overhead is 2 cycles.
- Backpressure: while tready_from_router=0 in HEADER, the header beat holds stable. In PAYLOAD, stalls propagate combinationally to the trans side.
- Single-beat payload: header, then 1 payload beat with tlast, then IDLE.
- Reset mid-frame: the state returns to IDLE immediately. The router sees a truncated frame with no tlast, which is intended; the router discards it on its own timeout. Counters clear.
- The seq counter is wrap-around only. The frames_dropped counter saturates.

## Structure
- The shared package `doce_tx_pkg` holds:
  - State encodings as one-hot localparams: IDLE=4'b0001, HEADER=4'b0010, PAYLOAD=4'b0100, DROP=4'b1000.
  - TUSER_DROP_BIT=2 and the header field bit offsets (SRC 0, DST 48, ETYPE 96, SEQ 112). The receive FSM shares these offsets.
- A single module; no sub-module is needed. The header mux is in-line combinational logic.

## Test plan
- Three-beat frame, tuser=4'h1, dst=0x0A0B0C0D0E0F, src=0x112233445566, router always ready.
  - Router sees 4 beats; beat 0 = {16'h0000, 16'h88B5, 48'h0A0B0C0D0E0F, 48'h112233445566}.
  - tuser=1 on all beats, tlast on beat 3, frames_sent=1.
- Two back-to-back frames: the second header carries seq=1, and there is exactly one idle cycle between the first tlast and the second header.
- Drop frame with tuser[2]=1 and 4 beats: all 4 beats are consumed, tvalid_to_router stays 0, frames_dropped=1, and seq is unchanged.
- Router tready toggles 1010… during header and payload: the header holds stable until accepted, every payload beat appears exactly once in order, and tkeep is preserved on the last beat (16'h00FF).
- tx_dst_mac_addr changes mid-frame, and reset asserts during beat 2 of a 5-beat frame:
  - The header keeps the originally latched MAC.
  - After reset, outputs are 0, state is IDLE, and the counters are 0.
  - The next frame carries seq=0.
- 65,537 frames are sent: the seq field wraps to 0x0000 and then 0x0001, and frames_sent=65537.
